// File: rtl/qspline_sdiv_32s_16s_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : qspline_sdiv_32s_16s_seq_if
//  Brief    : Operand/result handshake bundle for the sequential 32s/16s
//             signed divider. The err field exists only when
//             QSPLINE_SDIV_ERR_PORT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface qspline_sdiv_32s_16s_seq_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DIVIDEND_W-1:0] quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
  logic [1:0]                   err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
`endif
endinterface
`default_nettype wire

// File: rtl/qspline_sdiv_32s_16s_seq.sv
`default_nettype none
// ============================================================================
//  Module   : qspline_sdiv_32s_16s_seq
//  Brief    : Sequential signed divider (restoring, one quotient bit per
//             cycle), C truncation semantics, valid/ready on both sides.
//             Divide-by-zero and MIN/-1 saturate. Optional macro
//             QSPLINE_SDIV_ERR_PORT_EN adds a 2-bit err flag in the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module qspline_sdiv_32s_16s_seq #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  wire logic                  ap_clk,
  input  wire logic                  ap_rst_n,
  qspline_sdiv_32s_16s_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int REM_W = DIVISOR_W + 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DIVIDEND_W-1:0] Q_MAX    = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] Q_MIN    = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  // Holds |dividend| at start; quotient bits shift in at the LSB as the
  // dividend bits shift out at the MSB, so it ends as |quotient|.
  logic [DIVIDEND_W-1:0]   dvd_q,       dvd_d;
  logic [DIVISOR_W-1:0]    rem_q,       rem_d;
  logic [REM_W-1:0]        dvs_q,       dvs_d;
  logic                    q_neg_q,     q_neg_d;
  logic                    r_neg_q,     r_neg_d;
  logic                    div0_q,      div0_d;
  logic                    ovf_q,       ovf_d;
  logic [DIVIDEND_W-1:0]   quotient_q,  quotient_d;
  logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
  logic [1:0]              err_q,       err_d;
`endif

  // Operand preparation and one restoring step
  logic [DIVIDEND_W-1:0]   dvd_u;
  logic [DIVIDEND_W-1:0]   dvd_abs;
  logic [REM_W-1:0]        dvs_ext;
  logic [REM_W-1:0]        dvs_abs;
  logic [REM_W-1:0]        rem_shift;
  logic [REM_W:0]          trial;
  logic                    q_bit;
  logic                    trial_unused;

  assign dvd_u   = bus.dividend;
  assign dvd_abs = dvd_u[DIVIDEND_W-1] ? -dvd_u : dvd_u;
  // Sign-extend one bit so |MIN| is representable as an unsigned magnitude
  assign dvs_ext = {bus.divisor[DIVISOR_W-1], bus.divisor};
  assign dvs_abs = dvs_ext[REM_W-1] ? -dvs_ext : dvs_ext;

  assign rem_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
  assign trial     = {1'b0, rem_shift} - {1'b0, dvs_q};
  assign q_bit     = ~trial[REM_W];
  // A kept trial result is below |divisor|, so its top magnitude bit is zero
  assign trial_unused = trial[DIVISOR_W];

  // Next-state, datapath and output-register computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = dvd_abs;
          dvs_d   = dvs_abs;
          rem_d   = '0;
          r_neg_d = bus.dividend[DIVIDEND_W-1];
          q_neg_d = bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
          div0_d  = (bus.divisor == '0);
          ovf_d   = (dvd_u == Q_MIN) && (bus.divisor == '1);
          cnt_d   = CNT_LAST;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = q_bit ? trial[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
        dvd_d = {dvd_q[DIVIDEND_W-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIX: begin
        quotient_d  = q_neg_q ? -dvd_q : dvd_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
        err_d       = {ovf_q & ~div0_q, div0_q};
`endif
        if (div0_q) begin
          quotient_d  = r_neg_q ? Q_MIN : Q_MAX;
          remainder_d = '0;
        end else if (ovf_q) begin
          quotient_d  = Q_MAX;
          remainder_d = '0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef QSPLINE_SDIV_ERR_PORT_EN
  assign bus.err       = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qspline_sdiv_32s_16s_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qspline_sdiv_32s_16s_seq
//  Brief    : Self-checking bench for qspline_sdiv_32s_16s_seq (directed +
//             random operands against a plain-arithmetic reference).
//             Checks err when QSPLINE_SDIV_ERR_PORT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qspline_sdiv_32s_16s_seq;

  localparam int LAT = 34;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  qspline_sdiv_32s_16s_seq_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus ();

  qspline_sdiv_32s_16s_seq #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C-style truncating division with the saturation rules
  task automatic ref_div(input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [15:0] r, output logic [1:0] e);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      r = '0;
      e = 2'b01;
    end else if (sa == -64'sd2147483648 && sb == -1) begin
      q = 32'h7FFF_FFFF;
      r = '0;
      e = 2'b10;
    end else begin
      qq = sa / sb;
      rr = sa - qq * sb;
      q  = qq[31:0];
      r  = rr[15:0];
      e  = 2'b00;
    end
  endtask

  // Called just after the accepting edge; leaves the caller at the negedge
  // on which out_valid is first observed.
  task automatic wait_result(input logic [31:0] a, input logic [15:0] b, input string tag);
    logic [31:0] eq;
    logic [15:0] er;
    logic [1:0]  ee;
    int k;
    ref_div(a, b, eq, er, ee);
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(LAT));
    check({tag, " quotient"}, 64'($unsigned(bus.quotient)), 64'(eq));
    check({tag, " remainder"}, 64'($unsigned(bus.remainder)), 64'(er));
`ifdef QSPLINE_SDIV_ERR_PORT_EN
    check({tag, " err"}, 64'(bus.err), 64'(ee));
`else
    if (ee == 2'b11) check({tag, " err"}, 64'(ee), 64'd0);
`endif
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = 1'b1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    wait_result(a, b, tag);
    @(negedge clk);
    check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] a, eq;
    logic [15:0] b, er;
    logic [1:0]  ee;
    int mode, seen;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset quotient", 64'($unsigned(bus.quotient)), 64'd0);
    check("reset remainder", 64'($unsigned(bus.remainder)), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed sign and special cases
    run_op(32'd1000, 16'd7, "p/p");
    run_op(-32'sd1000, 16'd7, "n/p");
    run_op(32'd1000, -16'sd7, "p/n");
    run_op(-32'sd1000, -16'sd7, "n/n");
    run_op(32'd12345, 16'd0, "p/0");
    run_op(-32'sd5, 16'd0, "n/0");
    run_op(32'h8000_0000, 16'hFFFF, "min/-1");
    run_op(32'h8000_0000, 16'h8000, "min/min16");
    run_op(32'd0, 16'd9, "0/p");
    run_op(32'h7FFF_FFFF, 16'd1, "max/1");

    // Backpressure: result held for 10 cycles, next op waits in_valid high
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = 32'd777777;
    bus.divisor   = -16'sd123;
    bus.out_ready = 1'b0;
    @(posedge clk);
    wait_result(32'd777777, -16'sd123, "bp first");
    ref_div(32'd777777, -16'sd123, eq, er, ee);
    bus.in_valid = 1'b1;
    bus.dividend = -32'sd99999;
    bus.divisor  = 16'd17;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold valid", 64'(bus.out_valid), 64'd1);
      check("bp hold quotient", 64'($unsigned(bus.quotient)), 64'(eq));
      check("bp hold remainder", 64'($unsigned(bus.remainder)), 64'(er));
      check("bp in_ready low", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 64'(bus.out_valid), 64'd0);
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    wait_result(-32'sd99999, 16'd17, "bp second");
    @(negedge clk);
    check("bp second drop", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in CALC cycle 10
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst in_ready", 64'(bus.in_ready), 64'd1);
    check("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-rst quotient", 64'($unsigned(bus.quotient)), 64'd0);
    check("mid-rst remainder", 64'($unsigned(bus.remainder)), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("abandoned op silent", 64'(seen), 64'd0);
    run_op(32'd6, 16'd3, "post-rst");

    // Randomized operands with biased special values
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = 16'($urandom);
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 16'hFFFF; end
      else if (mode == 2) a = 32'h8000_0000;
      else if (mode == 3) b = 16'h8000;
      else if (mode == 4) a = 32'($signed(16'($urandom)));
      run_op(a, b, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspline_sdiv_32s_16s_seq.md
Name: qspline_sdiv_32s_16s_seq

Overview:
Sequential signed divider. It is the inverse companion of the qspline 16sx16s->32 multiplier: it recovers coefficient-scale values from 32-bit products, computing dividend / divisor with C truncation semantics. It uses restoring division at one quotient bit per cycle, with a valid/ready handshake on both sides. It is instantiated by the qspline datapath wherever a 32s/16s divide is scheduled as a multi-cycle operation.

Parameters:
DIVIDEND_W, 32, dividend and quotient width (signed); the iteration count equals DIVIDEND_W
DIVISOR_W, 16, divisor and remainder width (signed); must be <= DIVIDEND_W

Ports:
ap_clk  input  1  clock; all state updates on the rising edge
ap_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/divisor present
in_ready  output  1  block can accept an operation
dividend  input  DIVIDEND_W  signed dividend
divisor  input  DIVISOR_W  signed divisor
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
quotient  output  DIVIDEND_W  signed quotient, truncated toward zero
remainder  output  DIVISOR_W  signed remainder; sign follows the dividend

Behaviour:
- Reset is asynchronous and active-low: ap_rst_n=0 immediately forces state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, and clears internal registers. Reset mid-operation abandons the operation; no result is ever emitted for it.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch |dividend|, |divisor|, the sign of the dividend and the sign of the quotient (dividend sign XOR divisor sign), and the special-case flags. Go to CALC with the iteration counter = DIVIDEND_W-1.
  - CALC: in_ready=0. Each cycle: shift the partial remainder left by 1 and bring in the next dividend MSB. Trial-subtract |divisor|. If the result is non-negative, keep it and set quotient bit=1; otherwise restore and set the bit to 0. After the counter reaches 0, go to FIX. Exactly DIVIDEND_W cycles are spent in CALC.
  - FIX: one cycle. Apply the signs: negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative. Apply the special cases. Register the outputs and go to DONE.
  - DONE: out_valid=1 and the outputs are held stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: input handshake in cycle T gives out_valid=1 in cycle T+DIVIDEND_W+2, which is T+34 at the defaults.
- Throughput: one operation in flight. in_ready=1 only in IDLE; there is no combinational path from out_ready to in_ready.
- Arithmetic: the partial remainder is DIVISOR_W+1 bits, which avoids overflow on the trial subtract. The |x| of the most negative value is handled as an unsigned magnitude (for example, |-32768| = 32768 in 17 bits).
- Special cases, resolved in FIX; the CALC cycle count is unchanged so latency is constant:
  - divisor==0: quotient = max positive (0x7FFFFFFF) if dividend>=0, else min negative (0x80000000); remainder=0.
  - dividend = min negative and divisor = -1: quotient = 0x7FFFFFFF (saturated); remainder=0.
- Output hold: while out_valid=1 and out_ready=0, quotient and remainder must not change. in_valid is ignored outside IDLE.

Optional Feature:
QSPLINE_SDIV_ERR_PORT_EN
- Defined: adds output port err (2 bits), valid with out_valid and reset to 0. err[0] = divide-by-zero; err[1] = overflow (min negative / -1). Both bits are 0 for normal operations.
- Undefined: the port is absent. The saturation values are still produced; there is no other behavioural difference.

Test Plan:
- 1000 / 7, out_ready tied 1: in_valid at T -> out_valid at T+34 for exactly 1 cycle; quotient=142, remainder=6.
- -1000 / 7 -> quotient=-142, remainder=-6. 1000 / -7 -> quotient=-142, remainder=6. -1000 / -7 -> quotient=142, remainder=-6.
- 12345 / 0 -> quotient=0x7FFFFFFF, remainder=0. -5 / 0 -> quotient=0x80000000, remainder=0. With the macro defined, err=2'b01 in both cases.
- 0x80000000 / -1 -> quotient=0x7FFFFFFF, remainder=0, err=2'b10. Also 0x80000000 / -32768 -> quotient=65536, remainder=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs held stable and in_ready stays 0. A new in_valid held throughout is accepted only on the cycle after out_ready=1.
- Reset: assert ap_rst_n=0 during CALC cycle 10, asynchronously between clock edges -> in_ready=1 and out_valid=0 immediately. After release, 6 / 3 gives quotient=2, remainder=0 at T+34.
